// File: rtl/rf_commit_sequencer_pkg.sv
// Shared types and defines for the register-file commit sequencer: operand widths
// and the FSM state encoding.
`ifndef RF_COMMIT_SEQUENCER_DEFINES
`define RF_COMMIT_SEQUENCER_DEFINES
`define REG_INDEX_TYPE logic [4:0]
`define ROB_INDEX_TYPE logic [3:0]
`define DATA_TYPE logic [31:0]
`define REG_SIZE 32
`define FSM_STATE_RUN 2'd0
`define FSM_STATE_DRAIN 2'd1
`define FSM_STATE_CLEAR 2'd2
`endif

package rf_commit_sequencer_pkg;

  localparam int REG_INDEX_W = 5;
  localparam int ROB_INDEX_W = 4;
  localparam int DATA_W = 32;
  localparam int ENTRY_W = ROB_INDEX_W + REG_INDEX_W + DATA_W;

  typedef enum logic [1:0] {
    ST_RUN   = `FSM_STATE_RUN,
    ST_DRAIN = `FSM_STATE_DRAIN,
    ST_CLEAR = `FSM_STATE_CLEAR
  } state_t;

endpackage

// File: rtl/rf_commit_sequencer_fifo.sv
// Commit buffer: power-of-two circular FIFO with combinational head read.
// Pushes when full and pops when empty are ignored.
module commit_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 41
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Status flags and guarded push/pop enables
  always_comb begin
    full      = (count_r == DEPTH_CNT);
    empty     = (count_r == (PTR_W + 1)'(1'b0));
    count     = count_r;
    head      = mem_r[rd_ptr_r];
    push_ok_s = push && !full;
    pop_ok_s  = pop && !empty;
  end

  // Storage, pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W + 1){1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (PTR_W + 1)'(1'b1);
        2'b01:   count_r <= count_r - (PTR_W + 1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/rf_commit_sequencer.sv
// Register-file commit sequencer: buffers ROB commits, retires one per cycle, and on a
// flush drains the buffer then clears every dependency entry. RF_COMMIT_BYPASS_EN enables
// a zero-latency path when the buffer is empty.
module rf_commit_sequencer
  import rf_commit_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int REG_NUM    = `REG_SIZE
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           rdy_in,
  input  logic           rob_commit_valid,
  output logic           rob_commit_ready,
  input  `ROB_INDEX_TYPE rob_commit_rob_index,
  input  `REG_INDEX_TYPE rob_commit_reg_index,
  input  `DATA_TYPE      rob_commit_val,
  input  logic           flush_in,
  output logic           reg_commit,
  output `ROB_INDEX_TYPE reg_commit_rob_index,
  output `REG_INDEX_TYPE reg_commit_index,
  output `DATA_TYPE      reg_commit_val,
  output logic           reg_clear,
  output `REG_INDEX_TYPE reg_clear_index,
  output logic           issue_stall,
  output logic           flush_done,
  output logic           busy
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(REG_NUM);
  localparam logic [CNT_W-1:0] CLEAR_FIRST = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CLEAR_LAST  = CNT_W'(REG_NUM - 1);
  localparam logic [PTR_W:0]   ONE_ENTRY   = (PTR_W + 1)'(1'b1);

  state_t             state_r;
  logic [CNT_W-1:0]   counter_r;
  logic               flush_done_r;
  logic               run_en_r;
  logic               ready_s;
  logic               handshake_s;
  logic               bypass_s;
  logic               fifo_push_s;
  logic               fifo_pop_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic               empty_next_s;
  logic [PTR_W:0]     fifo_count_s;
  logic [ENTRY_W-1:0] fifo_wdata_s;
  logic [ENTRY_W-1:0] fifo_head_s;

  commit_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (fifo_push_s),
    .push_data (fifo_wdata_s),
    .pop       (fifo_pop_s),
    .head      (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  // Handshake, FIFO control and output muxing; run_en_r keeps ready low until after reset
  always_comb begin
    ready_s      = run_en_r && rdy_in && !flush_in && (state_r == ST_RUN) && !fifo_full_s;
    handshake_s  = ready_s && rob_commit_valid;
`ifdef RF_COMMIT_BYPASS_EN
    bypass_s     = handshake_s && fifo_empty_s && (rob_commit_reg_index != {REG_INDEX_W{1'b0}});
`else
    bypass_s     = 1'b0;
`endif
    fifo_push_s  = handshake_s && !bypass_s && (rob_commit_reg_index != {REG_INDEX_W{1'b0}});
    fifo_pop_s   = rdy_in && !fifo_empty_s && (state_r != ST_CLEAR);
    fifo_wdata_s = {rob_commit_rob_index, rob_commit_reg_index, rob_commit_val};
    empty_next_s = fifo_empty_s || (fifo_pop_s && (fifo_count_s == ONE_ENTRY));

    rob_commit_ready = ready_s;
    if (bypass_s) begin
      reg_commit = 1'b1;
      {reg_commit_rob_index, reg_commit_index, reg_commit_val} = fifo_wdata_s;
    end else if (fifo_pop_s) begin
      reg_commit = 1'b1;
      {reg_commit_rob_index, reg_commit_index, reg_commit_val} = fifo_head_s;
    end else begin
      reg_commit = 1'b0;
      {reg_commit_rob_index, reg_commit_index, reg_commit_val} = {ENTRY_W{1'b0}};
    end

    reg_clear = rdy_in && (state_r == ST_CLEAR);
    if (reg_clear) begin
      reg_clear_index = REG_INDEX_W'(counter_r);
    end else begin
      reg_clear_index = {REG_INDEX_W{1'b0}};
    end
    flush_done  = flush_done_r && rdy_in;
    issue_stall = flush_in || (state_r != ST_RUN);
    busy        = !fifo_empty_s || (state_r != ST_RUN);
  end

  // Flush sequencing FSM; every state change waits for rdy_in
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_r      <= ST_RUN;
      counter_r    <= {CNT_W{1'b0}};
      flush_done_r <= 1'b0;
      run_en_r     <= 1'b0;
    end else begin
      run_en_r <= 1'b1;
      if (rdy_in) begin
        flush_done_r <= 1'b0;
        case (state_r)
          ST_RUN: begin
            if (flush_in && empty_next_s) begin
              state_r   <= ST_CLEAR;
              counter_r <= CLEAR_FIRST;
            end else if (flush_in) begin
              state_r <= ST_DRAIN;
            end else begin
              state_r <= ST_RUN;
            end
          end
          ST_DRAIN: begin
            if (empty_next_s) begin
              state_r   <= ST_CLEAR;
              counter_r <= CLEAR_FIRST;
            end else begin
              state_r <= ST_DRAIN;
            end
          end
          ST_CLEAR: begin
            counter_r <= counter_r + CNT_W'(1'b1);
            if (counter_r == CLEAR_LAST) begin
              state_r      <= ST_RUN;
              flush_done_r <= 1'b1;
            end else begin
              state_r <= ST_CLEAR;
            end
          end
          default: begin
            state_r   <= ST_RUN;
            counter_r <= {CNT_W{1'b0}};
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rf_commit_sequencer.sv
// Directed bench for rf_commit_sequencer: inputs change on the falling edge and outputs
// are sampled 1 ns later, well clear of the rising edge.
module tb_rf_commit_sequencer;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        rob_commit_valid = 1'b0;
  logic        rob_commit_ready;
  logic [3:0]  rob_commit_rob_index = 4'd0;
  logic [4:0]  rob_commit_reg_index = 5'd0;
  logic [31:0] rob_commit_val = 32'd0;
  logic        flush_in = 1'b0;
  logic        reg_commit;
  logic [3:0]  reg_commit_rob_index;
  logic [4:0]  reg_commit_index;
  logic [31:0] reg_commit_val;
  logic        reg_clear;
  logic [4:0]  reg_clear_index;
  logic        issue_stall;
  logic        flush_done;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  rf_commit_sequencer dut (
    .clk_in               (clk_in),
    .rst_in               (rst_in),
    .rdy_in               (rdy_in),
    .rob_commit_valid     (rob_commit_valid),
    .rob_commit_ready     (rob_commit_ready),
    .rob_commit_rob_index (rob_commit_rob_index),
    .rob_commit_reg_index (rob_commit_reg_index),
    .rob_commit_val       (rob_commit_val),
    .flush_in             (flush_in),
    .reg_commit           (reg_commit),
    .reg_commit_rob_index (reg_commit_rob_index),
    .reg_commit_index     (reg_commit_index),
    .reg_commit_val       (reg_commit_val),
    .reg_clear            (reg_clear),
    .reg_clear_index      (reg_clear_index),
    .issue_stall          (issue_stall),
    .flush_done           (flush_done),
    .busy                 (busy)
  );

  task automatic drive_idle();
    rdy_in = 1'b1;
    rob_commit_valid = 1'b0;
    rob_commit_rob_index = 4'd0;
    rob_commit_reg_index = 5'd0;
    rob_commit_val = 32'd0;
    flush_in = 1'b0;
  endtask

  task automatic drive_commit(input logic [3:0] rob, input logic [4:0] rg, input logic [31:0] v);
    rob_commit_valid = 1'b1;
    rob_commit_rob_index = rob;
    rob_commit_reg_index = rg;
    rob_commit_val = v;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_in = 1'b0;
    #12;
    checks++;
    if ({rob_commit_ready, reg_commit, reg_clear, flush_done, busy, issue_stall} !== 6'b0) begin
      errors++;
      $display("FAIL reset_strobes got %b exp 000000",
               {rob_commit_ready, reg_commit, reg_clear, flush_done, busy, issue_stall});
    end
    checks++;
    if ({reg_commit_rob_index, reg_commit_index, reg_commit_val, reg_clear_index} !== 46'd0) begin
      errors++;
      $display("FAIL reset_fields got %h exp 0",
               {reg_commit_rob_index, reg_commit_index, reg_commit_val, reg_clear_index});
    end
    #11 rst_in = 1'b1;
    @(negedge clk_in); #1;
    checks++;
    if ({rob_commit_ready, busy, issue_stall} !== 3'b100) begin
      errors++;
      $display("FAIL reset_release got %b exp 100", {rob_commit_ready, busy, issue_stall});
    end
  endtask

  task automatic test_single();
    @(negedge clk_in);
    drive_commit(4'd3, 5'd5, 32'hDEADBEEF);
    #1;
    checks++;
    if (rob_commit_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_ready got %b exp 1", rob_commit_ready);
    end
`ifdef RF_COMMIT_BYPASS_EN
    checks++;
    if ({reg_commit, reg_commit_rob_index, reg_commit_index, reg_commit_val} !== {1'b1, 4'd3, 5'd5, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL single_bypass got %b/%0d/%0d/%h exp 1/3/5/deadbeef",
               reg_commit, reg_commit_rob_index, reg_commit_index, reg_commit_val);
    end
`else
    checks++;
    if (reg_commit !== 1'b0) begin
      errors++;
      $display("FAIL single_early got %b exp 0", reg_commit);
    end
`endif
    @(negedge clk_in);
    drive_idle();
    #1;
`ifndef RF_COMMIT_BYPASS_EN
    checks++;
    if ({reg_commit, reg_commit_rob_index, reg_commit_index, reg_commit_val} !== {1'b1, 4'd3, 5'd5, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL single_commit got %b/%0d/%0d/%h exp 1/3/5/deadbeef",
               reg_commit, reg_commit_rob_index, reg_commit_index, reg_commit_val);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy got %b exp 1", busy);
    end
    @(negedge clk_in); #1;
`endif
    checks++;
    if ({reg_commit, busy} !== 2'b00) begin
      errors++;
      $display("FAIL single_idle got %b exp 00", {reg_commit, busy});
    end
  endtask

  // Scoreboard-driven burst of 6 commits, optionally with rdy_in low for 3 cycles
  task automatic test_back_to_back(input bit stall);
    logic [40:0] q[$];
    logic        exp_ready;
    logic        exp_commit;
    int          sent = 0;
    int          seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_in);
      rdy_in = (stall && c >= 2 && c <= 4) ? 1'b0 : 1'b1;
      if (sent < 6) begin
        drive_commit(4'(sent + 1), 5'(10 + sent), 32'hA0000000 + 32'(sent));
      end else begin
        rob_commit_valid = 1'b0;
      end
      #1;
      exp_ready  = rdy_in && (q.size() < 4);
      exp_commit = rdy_in && (q.size() > 0);
      checks++;
      if (rob_commit_ready !== exp_ready) begin
        errors++;
        $display("FAIL burst_ready c=%0d got %b exp %b", c, rob_commit_ready, exp_ready);
      end
      checks++;
      if (reg_commit !== exp_commit) begin
        errors++;
        $display("FAIL burst_commit c=%0d got %b exp %b", c, reg_commit, exp_commit);
      end
      if (reg_commit === 1'b1) seen++;
      if (exp_commit) begin
        checks++;
        if ({reg_commit_rob_index, reg_commit_index, reg_commit_val} !== q[0]) begin
          errors++;
          $display("FAIL burst_data c=%0d got %h exp %h", c,
                   {reg_commit_rob_index, reg_commit_index, reg_commit_val}, q[0]);
        end
        void'(q.pop_front());
      end
      if (exp_ready && rob_commit_valid) begin
        q.push_back({rob_commit_rob_index, rob_commit_reg_index, rob_commit_val});
        sent++;
      end
    end
    checks++;
    if (seen != 6) begin
      errors++;
      $display("FAIL burst_count got %0d exp 6", seen);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL burst_busy got %b exp 0", busy);
    end
    drive_idle();
  endtask

  task automatic test_x0();
    @(negedge clk_in);
    drive_commit(4'd2, 5'd0, 32'd7);
    #1;
    checks++;
    if (rob_commit_ready !== 1'b1) begin
      errors++;
      $display("FAIL x0_ready got %b exp 1", rob_commit_ready);
    end
    @(negedge clk_in);
    drive_idle();
    #1;
    checks++;
    if ({reg_commit, busy} !== 2'b00) begin
      errors++;
      $display("FAIL x0_discard got %b exp 00", {reg_commit, busy});
    end
  endtask

  // Flush with a commit in flight; optional rdy_in gap and a second flush_in mid-CLEAR
  task automatic test_flush(input bit rdy_gap, input bit reflush);
    int   idx = 1;
    bit   done = 1'b0;
    int   dut_done_k = -1;
    logic exp_clear;
    logic exp_done;
    logic exp_stall;
    logic exp_ready;
    @(negedge clk_in);
    drive_commit(4'd1, 5'd9, 32'h55);
    #1;
    checks++;
    if (rob_commit_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre_ready got %b exp 1", rob_commit_ready);
    end
    @(negedge clk_in);
    drive_commit(4'd2, 5'd11, 32'h66);
    flush_in = 1'b1;
    #1;
    checks++;
    if ({rob_commit_ready, issue_stall} !== 2'b01) begin
      errors++;
      $display("FAIL flush_req got ready/stall %b exp 01", {rob_commit_ready, issue_stall});
    end
    checks++;
    if ({reg_commit, reg_commit_rob_index, reg_commit_index, reg_commit_val} !== {1'b1, 4'd1, 5'd9, 32'h55}) begin
      errors++;
      $display("FAIL flush_drain got %b/%0d/%0d/%h exp 1/1/9/55",
               reg_commit, reg_commit_rob_index, reg_commit_index, reg_commit_val);
    end
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk_in);
      rob_commit_valid = 1'b0;
      flush_in = reflush && (k == 10);
      rdy_in = !(rdy_gap && (k == 5 || k == 6));
      #1;
      exp_clear = rdy_in && (idx <= 31);
      exp_done  = rdy_in && (idx == 32) && !done;
      exp_stall = flush_in || (idx <= 31);
      exp_ready = rdy_in && !flush_in && (idx > 31);
      checks++;
      if ({reg_clear, reg_clear_index} !== {exp_clear, exp_clear ? 5'(idx) : 5'd0}) begin
        errors++;
        $display("FAIL flush_clear k=%0d got %b/%0d exp %b/%0d", k, reg_clear, reg_clear_index,
                 exp_clear, exp_clear ? idx : 0);
      end
      checks++;
      if ({reg_commit, flush_done} !== {1'b0, exp_done}) begin
        errors++;
        $display("FAIL flush_done k=%0d got commit/done %b exp 0%b", k, {reg_commit, flush_done}, exp_done);
      end
      checks++;
      if ({issue_stall, rob_commit_ready, busy} !== {exp_stall, exp_ready, idx <= 31}) begin
        errors++;
        $display("FAIL flush_status k=%0d got stall/ready/busy %b exp %b", k,
                 {issue_stall, rob_commit_ready, busy}, {exp_stall, exp_ready, idx <= 31});
      end
      if (flush_done === 1'b1) dut_done_k = k;
      if (exp_clear) idx++;
      if (exp_done) done = 1'b1;
    end
    checks++;
    if (dut_done_k != (rdy_gap ? 34 : 32)) begin
      errors++;
      $display("FAIL flush_done_cycle got %0d exp %0d", dut_done_k, rdy_gap ? 34 : 32);
    end
    drive_idle();
  endtask

  task automatic test_reset_mid_clear();
    int done_cnt = 0;
    @(negedge clk_in);
    flush_in = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_in);
      flush_in = 1'b0;
    end
    #2 rst_in = 1'b0;
    #1;
    checks++;
    if ({rob_commit_ready, reg_commit, reg_clear, reg_clear_index, flush_done, busy, issue_stall} !== 11'd0) begin
      errors++;
      $display("FAIL midreset_outputs got %b exp 0",
               {rob_commit_ready, reg_commit, reg_clear, reg_clear_index, flush_done, busy, issue_stall});
    end
    @(negedge clk_in);
    #2 rst_in = 1'b1;
    @(negedge clk_in);
    drive_commit(4'd7, 5'd20, 32'h12345678);
    #1;
    checks++;
    if ({rob_commit_ready, issue_stall, busy} !== 3'b100) begin
      errors++;
      $display("FAIL midreset_run got %b exp 100", {rob_commit_ready, issue_stall, busy});
    end
    @(negedge clk_in);
    drive_idle();
    #1;
    checks++;
    if ({reg_commit, reg_commit_rob_index, reg_commit_index, reg_commit_val} !== {1'b1, 4'd7, 5'd20, 32'h12345678}) begin
      errors++;
      $display("FAIL midreset_commit got %b/%0d/%0d/%h exp 1/7/20/12345678",
               reg_commit, reg_commit_rob_index, reg_commit_index, reg_commit_val);
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_in); #1;
      if (flush_done === 1'b1 || reg_clear === 1'b1) done_cnt++;
    end
    checks++;
    if (done_cnt != 0) begin
      errors++;
      $display("FAIL midreset_no_done got %0d exp 0", done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back(1'b0);
    test_back_to_back(1'b1);
    test_x0();
    test_flush(1'b0, 1'b0);
    test_flush(1'b1, 1'b1);
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
